// File: rtl/sonic_rx_fetch_pkg.sv
// Shared types for the RX ring block fetcher: FSM state encoding and the
// FIFO entry that carries a returned oword with its framing flags.
package sonic_rx_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
  } fifo_entry_t;

endpackage

// File: rtl/sonic_rx_fetch_fifo.sv
// Small synchronous FIFO of framed owords with occupancy count and flush.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sonic_rx_fetch_fifo
  import sonic_rx_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_in,
  input  logic              rstn,
  input  logic              flush,
  input  logic              push,
  input  fifo_entry_t       push_entry,
  input  logic              pop,
  output fifo_entry_t       head,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  fifo_entry_t      mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             do_push;
  logic             do_pop;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_idx];

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_in) begin
    if (!rstn || flush) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= next_idx(wr_idx);
      if (do_pop)  rd_idx <= next_idx(rd_idx);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; validity comes from count alone.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_idx] <= push_entry;
  end

endmodule

// File: rtl/sonic_rx_block_fetch.sv
// Reads whole blocks out of the RX circular buffer once enough data has been
// written, and streams them as SOP/EOP framed owords under FIFO credit.
module sonic_rx_block_fetch
  import sonic_rx_fetch_pkg::*;
#(
  parameter int QPTR_W     = 12,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rstn,
  input  logic              enable_sfp,
  input  logic [QPTR_W-1:0] rx_ring_wptr,
  input  logic [QPTR_W-2:0] blk_owords,
  output logic              rd_req,
  output logic [QPTR_W-2:0] rd_address_owords,
  input  logic [127:0]      rd_data,
  output logic [127:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              block_done,
  output logic              block_abort,
  output logic [QPTR_W-1:0] rx_ring_rptr
);

  localparam int OPTR_W = QPTR_W - 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W   = $clog2(RD_LATENCY + 1);

  fetch_state_e          state;
  logic [OPTR_W-1:0]     rptr_o;
  logic [OPTR_W-1:0]     blk_len;
  logic [OPTR_W-1:0]     issue_cnt;
  logic [RD_LATENCY-1:0] vld_sr;
  logic [RD_LATENCY-1:0] sop_sr;
  logic [RD_LATENCY-1:0] eop_sr;
  logic [QPTR_W-1:0]     avail_q;
  logic [IF_W-1:0]       in_flight;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  fifo_entry_t           fifo_head;
  fifo_entry_t           fifo_in;
  logic                  start_blk;
  logic                  credit_ok;
  logic                  issue;
  logic                  last_issue;
  logic                  beat_pop;

  assign rx_ring_rptr = {rptr_o, 1'b0};
  assign avail_q      = rx_ring_wptr - rx_ring_rptr;
  assign start_blk    = (state == IDLE) && enable_sfp && (blk_owords != '0) &&
                        ({1'b0, avail_q} >= {1'b0, blk_owords, 1'b0});

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + IF_W'(vld_sr[i]);
  end

  // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
  assign credit_ok  = (int'(in_flight) + int'(fifo_count)) < FIFO_DEPTH;
  assign issue      = (state == FETCH) && enable_sfp && credit_ok;
  assign last_issue = (issue_cnt == blk_len - 1'b1);

  assign rd_req            = issue;
  assign rd_address_owords = rptr_o;

  assign fifo_in  = '{data: rd_data, sop: sop_sr[RD_LATENCY-1], eop: eop_sr[RD_LATENCY-1]};
  assign beat_pop = out_valid & out_ready;

  sonic_rx_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in     (clk_in),
    .rstn       (rstn),
    .flush      (~enable_sfp),
    .push       (vld_sr[RD_LATENCY-1]),
    .push_entry (fifo_in),
    .pop        (beat_pop),
    .head       (fifo_head),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // Head contents are gated so an empty FIFO presents all-zero outputs.
  assign out_valid  = ~fifo_empty;
  assign out_data   = out_valid ? fifo_head.data : '0;
  assign out_sop    = out_valid & fifo_head.sop;
  assign out_eop    = out_valid & fifo_head.eop;
  assign block_done = beat_pop & out_eop;

  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state       <= IDLE;
      rptr_o      <= '0;
      blk_len     <= '0;
      issue_cnt   <= '0;
      vld_sr      <= '0;
      sop_sr      <= '0;
      eop_sr      <= '0;
      block_abort <= 1'b0;
    end else if (!enable_sfp) begin
      state       <= IDLE;
      rptr_o      <= '0;
      issue_cnt   <= '0;
      vld_sr      <= '0;
      block_abort <= (state != IDLE);
    end else begin
      block_abort <= 1'b0;
      vld_sr[0]   <= issue;
      sop_sr[0]   <= (issue_cnt == '0);
      eop_sr[0]   <= last_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        sop_sr[i] <= sop_sr[i-1];
        eop_sr[i] <= eop_sr[i-1];
      end
      case (state)
        IDLE: begin
          if (start_blk) begin
            blk_len   <= blk_owords;
            issue_cnt <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            rptr_o    <= rptr_o + 1'b1;
            issue_cnt <= issue_cnt + 1'b1;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (block_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_rx_block_fetch.sv
// Directed bench for sonic_rx_block_fetch: a buffer model answers reads, and
// scoreboards of expected read addresses and framed beats check the outputs.
module tb_sonic_rx_block_fetch;

  typedef struct {
    logic [127:0] data;
    logic         sop;
    logic         eop;
  } beat_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic         rstn, enable_sfp;
  logic [11:0]  wptr, rptr;
  logic [10:0]  blk, rd_addr;
  logic         rd_req, out_valid, out_ready, out_sop, out_eop, block_done, block_abort;
  logic [127:0] rd_data, out_data;

  logic [3:0]   wptr4, rptr4;
  logic [2:0]   blk4, rd_addr4;
  logic         rd_req4, out_valid4, out_ready4, out_sop4, out_eop4, block_done4, block_abort4;
  logic [127:0] rd_data4, out_data4;

  sonic_rx_block_fetch #(.QPTR_W(12), .RD_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rstn(rstn), .enable_sfp(enable_sfp), .rx_ring_wptr(wptr),
    .blk_owords(blk), .rd_req(rd_req), .rd_address_owords(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .block_done(block_done), .block_abort(block_abort),
    .rx_ring_rptr(rptr)
  );

  sonic_rx_block_fetch #(.QPTR_W(4), .RD_LATENCY(2), .FIFO_DEPTH(4)) dut4 (
    .clk_in(clk_in), .rstn(rstn), .enable_sfp(enable_sfp), .rx_ring_wptr(wptr4),
    .blk_owords(blk4), .rd_req(rd_req4), .rd_address_owords(rd_addr4), .rd_data(rd_data4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4), .out_sop(out_sop4),
    .out_eop(out_eop4), .block_done(block_done4), .block_abort(block_abort4),
    .rx_ring_rptr(rptr4)
  );

  function automatic logic [127:0] pat(input int unsigned a);
    return {32'hC0DE_0000 + a, 32'h5A5A_0000 ^ a, a * 32'd7 + 32'd1, ~a};
  endfunction

  // Buffer model: data for the address requested two cycles earlier.
  logic [10:0] p1, p2;
  logic [2:0]  p1_4, p2_4;
  always @(posedge clk_in) begin
    p1   <= rd_addr;  p2   <= p1;
    p1_4 <= rd_addr4; p2_4 <= p1_4;
  end
  assign rd_data  = pat(32'(p2));
  assign rd_data4 = pat(32'(p2_4));

  int    pass_cnt = 0, fail_cnt = 0;
  int    cyc = 0, rd_cnt = 0, beat_cnt = 0, done_cnt = 0, abort_cnt = 0, done4_cnt = 0;
  int    addr_q[$], addr4_q[$], rd_cyc_q[$];
  beat_t beat_q[$], beat4_q[$];

  always @(posedge clk_in) cyc++;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic push_block(input int start, input int len, input int ring, input bit four);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (start + i) % ring;
      if (four) begin
        addr4_q.push_back(a);
        beat4_q.push_back('{data: pat(a), sop: (i == 0), eop: (i == len - 1)});
      end else begin
        addr_q.push_back(a);
        beat_q.push_back('{data: pat(a), sop: (i == 0), eop: (i == len - 1)});
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic wait_done4(input int target, input int budget);
    int k = 0;
    while (done4_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    check("done4_count", done4_cnt, target);
  endtask

  always @(negedge clk_in) begin
    if (rd_req) begin
      rd_cnt++;
      rd_cyc_q.push_back(cyc);
      check("rd_req_pending", (addr_q.size() != 0), 1'b1);
      if (addr_q.size() != 0) check("rd_addr", rd_addr, addr_q.pop_front());
    end
    if (out_valid && out_ready) begin
      beat_cnt++;
      check("beat_pending", (beat_q.size() != 0), 1'b1);
      if (beat_q.size() != 0) begin
        beat_t e;
        e = beat_q.pop_front();
        check("beat", {out_sop, out_eop, out_data}, {e.sop, e.eop, e.data});
      end
    end
    if (block_done)  done_cnt++;
    if (block_abort) abort_cnt++;
    if (rd_req4) begin
      check("rd4_req_pending", (addr4_q.size() != 0), 1'b1);
      if (addr4_q.size() != 0) check("rd4_addr", rd_addr4, addr4_q.pop_front());
    end
    if (out_valid4 && out_ready4) begin
      check("beat4_pending", (beat4_q.size() != 0), 1'b1);
      if (beat4_q.size() != 0) begin
        beat_t e;
        e = beat4_q.pop_front();
        check("beat4", {out_sop4, out_eop4, out_data4}, {e.sop, e.eop, e.data});
      end
    end
    if (block_done4) done4_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, span, lat, ab0, d0, k;

    rstn = 1'b0; enable_sfp = 1'b1; wptr = '0; blk = 11'd4; out_ready = 1'b1;
    wptr4 = '0; blk4 = 3'd6; out_ready4 = 1'b1;
    step(3);
    check("reset_ctl", {rd_req, out_valid, out_sop, out_eop, block_done, block_abort}, 6'b0);
    check("reset_data", out_data, 128'b0);
    check("reset_rptr", {rptr, rd_addr, rptr4}, '0);
    rstn = 1'b1;
    step(5);
    check("idle_no_req", rd_cnt, 0);

    // Basic 4-oword block from address 0
    push_block(0, 4, 2048, 1'b0);
    rd_cyc_q.delete();
    wptr = 12'd8;
    wait_done(1, 40);
    step(3);
    check("done_single", done_cnt, 1);
    check("rptr_blk1", rptr, 12'd8);
    span = (rd_cyc_q.size() == 4) ? rd_cyc_q[3] - rd_cyc_q[0] : -1;
    check("rd_consecutive", span, 3);

    // One qword short of a block, then exactly enough
    wptr = 12'd15;
    base = rd_cnt;
    step(50);
    check("short_no_req", rd_cnt - base, 0);
    push_block(4, 4, 2048, 1'b0);
    rd_cyc_q.delete();
    wptr = 12'd16;
    base = cyc;
    wait_done(2, 40);
    lat = (rd_cyc_q.size() != 0) ? rd_cyc_q[0] - base : -1;
    check("first_req_latency", (lat >= 1 && lat <= 2), 1'b1);
    check("rptr_blk2", rptr, 12'd16);

    // 16-oword block under backpressure, then random ready
    blk = 11'd16;
    out_ready = 1'b0;
    push_block(8, 16, 2048, 1'b0);
    base = rd_cnt;
    wptr = 12'd48;
    step(30);
    check("stall_reads", rd_cnt - base, 4);
    check("stall_valid", out_valid, 1'b1);
    k = 0;
    while (done_cnt < 3 && k < 600) begin
      out_ready = 1'($urandom_range(0, 1));
      step(1);
      k++;
    end
    out_ready = 1'b1;
    check("done_count", done_cnt, 3);
    check("rptr_blk3", rptr, 12'd48);
    check("queues_empty", {addr_q.size(), beat_q.size()}, 64'd0);

    // Abort after two accepted beats
    blk = 11'd4;
    push_block(24, 4, 2048, 1'b0);
    base = beat_cnt;
    wptr = 12'd56;
    k = 0;
    while (beat_cnt < base + 2 && k < 40) begin
      step(1);
      k++;
    end
    enable_sfp = 1'b0;
    out_ready  = 1'b0;
    ab0 = abort_cnt;
    d0  = done_cnt;
    step(1);
    check("abort_pulse", block_abort, 1'b1);
    check("abort_state", {out_valid, rd_req, rptr}, '0);
    check("abort_beats", beat_cnt - base, 2);
    check("abort_issued_all", addr_q.size(), 0);
    beat_q.delete();
    step(3);
    check("abort_single", abort_cnt - ab0, 1);
    check("abort_no_eop", done_cnt, d0);
    enable_sfp = 1'b1;
    out_ready  = 1'b1;
    push_block(0, 4, 2048, 1'b0);
    wptr = 12'd8;
    wait_done(d0 + 1, 40);
    check("rptr_reenable", rptr, 12'd8);

    // Reset in the middle of a fetch
    blk = 11'd16;
    out_ready = 1'b0;
    push_block(4, 16, 2048, 1'b0);
    base = rd_cnt;
    wptr = 12'd40;
    k = 0;
    while (rd_cnt < base + 2 && k < 20) begin
      step(1);
      k++;
    end
    ab0 = abort_cnt;
    rstn = 1'b0;
    step(1);
    check("rst_mid_ctl", {rd_req, out_valid, out_sop, out_eop, block_done, block_abort}, 6'b0);
    check("rst_mid_data", {out_data, rptr}, '0);
    addr_q.delete();
    beat_q.delete();
    blk = '0;
    out_ready = 1'b1;
    step(2);
    rstn = 1'b1;
    base = rd_cnt;
    step(6);
    check("rst_no_abort", abort_cnt, ab0);
    check("blk0_no_req", rd_cnt - base, 0);

    // Narrow ring: block of 6 then a block of 4 that wraps
    push_block(0, 6, 8, 1'b1);
    wptr4 = 4'd12;
    wait_done4(1, 60);
    check("rptr4_blk1", rptr4, 4'd12);
    blk4 = 3'd4;
    push_block(6, 4, 8, 1'b1);
    wptr4 = 4'd4;
    wait_done4(2, 60);
    check("rptr4_wrap", rptr4, 4'd4);
    check("queues4_empty", {addr4_q.size(), beat4_q.size()}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
